// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset core control path.
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_SLL    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_XOR    = 4'd6,
    ALU_SRL    = 4'd7,
    ALU_SRA    = 4'd8,
    ALU_PASS_B = 4'd9
  } alu_cmd_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'd0,
    RES_MEM    = 2'd1,
    RES_ALU    = 2'd2
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC     = 2'd0,
    SRCA_OLD_PC = 2'd1,
    SRCA_RS1    = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } src_b_e;

  typedef enum logic [3:0] {
    ST_BOOT, ST_FETCH, ST_DECODE, ST_MEM_ADR, ST_MEM_READ, ST_MEM_WB, ST_MEM_WRITE,
    ST_EXEC_R, ST_EXEC_I, ST_EXEC_U, ST_ALU_WB, ST_JAL, ST_BEQ, ST_FAULT
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ILLEGAL = 2'd1,
    FC_TIMEOUT = 2'd2
  } fault_cause_e;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic imm_src_e imm_for_op(input logic [6:0] op);
    case (op)
      OP_I, OP_LOAD: return IMM_I;
      OP_STORE:      return IMM_S;
      OP_BRANCH:     return IMM_B;
      OP_JAL:        return IMM_J;
      OP_LUI:        return IMM_U;
      default:       return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_decoder.sv
// Maps funct3 / funct7[5] / opcode[5] to the ALU command for R- and I-type ops.
module alu_cmd_decoder
  import core_pkg::*;
(
  input  logic [2:0] funct_3,
  input  logic       funct_7_bit_5,
  input  logic       op_bit_5,
  output alu_cmd_e   alu_cmd
);

  // funct7[5] only selects SUB on register ops; on addi it is an immediate bit.
  always_comb begin
    alu_cmd = ALU_ADD;
    case (funct_3)
      3'b000:  alu_cmd = (op_bit_5 && funct_7_bit_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_cmd = ALU_SLL;
      3'b010:  alu_cmd = ALU_SLT;
      3'b100:  alu_cmd = ALU_XOR;
      3'b101:  alu_cmd = funct_7_bit_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_cmd = ALU_OR;
      3'b111:  alu_cmd = ALU_AND;
      default: alu_cmd = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle core: fetch/decode/execute control,
// shared memory port handshake with watchdog, and sticky fault trapping.
module multicycle_controller
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_code,
  input  logic [2:0] funct_3,
  input  logic       funct_7_bit_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       instr_retire,
  output logic       fault,
  output logic [1:0] fault_cause
);

  // A disabled watchdog still needs a 1-bit counter to keep the code legal.
  localparam int unsigned WD_W = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  ctrl_state_e     state_q, state_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  fault_cause_e    cause_q, cause_d;
  logic            wd_expire;
  alu_cmd_e        exec_cmd;

  alu_cmd_decoder u_alu_dec (
    .funct_3       (funct_3),
    .funct_7_bit_5 (funct_7_bit_5),
    .op_bit_5      (op_code[5]),
    .alu_cmd       (exec_cmd)
  );

  // This stalled cycle is the TIMEOUT_CYCLES-th in a row; a ready arriving now takes priority.
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);

  // State, watchdog and fault cause registers; reset drops the memory request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      wd_cnt_q <= '0;
      cause_q  <= FC_NONE;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
      cause_q  <= cause_d;
    end
  end

  // Next-state logic; the watchdog clears whenever no access is stalling.
  always_comb begin
    state_d  = state_q;
    wd_cnt_d = '0;
    cause_d  = cause_q;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH, ST_MEM_READ, ST_MEM_WRITE: begin
        if (mem_ready) begin
          case (state_q)
            ST_FETCH:    state_d = ST_DECODE;
            ST_MEM_READ: state_d = ST_MEM_WB;
            default:     state_d = ST_FETCH;
          endcase
        end else if (wd_expire) begin
          state_d = ST_FAULT;
          cause_d = FC_TIMEOUT;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      ST_DECODE: begin
        case (op_code)
          OP_LOAD, OP_STORE: state_d = ST_MEM_ADR;
          OP_R:              state_d = ST_EXEC_R;
          OP_I:              state_d = ST_EXEC_I;
          OP_LUI:            state_d = ST_EXEC_U;
          OP_JAL:            state_d = ST_JAL;
          OP_BRANCH:         state_d = ST_BEQ;
          default: begin
            state_d = ST_FAULT;
            cause_d = FC_ILLEGAL;
          end
        endcase
      end
      ST_MEM_ADR: state_d = op_code[5] ? ST_MEM_WRITE : ST_MEM_READ;
      ST_EXEC_R, ST_EXEC_I, ST_EXEC_U, ST_JAL: state_d = ST_ALU_WB;
      ST_MEM_WB, ST_ALU_WB, ST_BEQ: state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Moore outputs per state, plus the ready-gated fetch/store strobes and branch-taken PC write.
  always_comb begin
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    adr_src      = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    imm_src      = IMM_I;
    alu_control  = ALU_ADD;
    instr_retire = 1'b0;
    fault        = 1'b0;
    fault_cause  = cause_q;
    if (state_q != ST_BOOT && state_q != ST_FAULT) imm_src = imm_for_op(op_code);
    case (state_q)
      ST_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
      end
      ST_MEM_WB: begin
        result_src   = RES_MEM;
        reg_write    = 1'b1;
        instr_retire = 1'b1;
      end
      ST_MEM_WRITE: begin
        adr_src      = 1'b1;
        mem_req      = 1'b1;
        mem_write    = 1'b1;
        instr_retire = mem_ready;
      end
      ST_EXEC_R: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = exec_cmd;
      end
      ST_EXEC_I: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = exec_cmd;
      end
      ST_EXEC_U: begin
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_PASS_B;
      end
      ST_ALU_WB: begin
        reg_write    = 1'b1;
        instr_retire = 1'b1;
      end
      ST_JAL: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      ST_BEQ: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_RS2;
        alu_control  = ALU_SUB;
        pc_write     = zero;
        instr_retire = 1'b1;
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step model, directed cases, random traffic.
module tb_multicycle_controller;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_code;
  logic [2:0] funct_3;
  logic       funct_7_bit_5, zero, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       instr_retire, fault;
  logic [1:0] fault_cause;

  multicycle_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct_3(funct_3),
    .funct_7_bit_5(funct_7_bit_5), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .instr_retire(instr_retire),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef enum {K_R, K_I, K_U, K_JAL, K_BEQ, K_LW, K_SW, K_ILL} kind_t;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] res, a, b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       retire, flt;
    logic [1:0] cause;
  } outs_t;

  int total = 0;
  int bad   = 0;

  // Model: step index inside the current instruction (0 = fetch, 1 = decode, ...).
  bit         m_boot, m_fault;
  logic [1:0] m_cause;
  int         m_step, m_stall;

  // ALU command by funct3 before the SUB/SRA modifiers.
  logic [3:0] alu_tab [8] = '{4'd0, 4'd4, 4'd5, 4'd0, 4'd6, 4'd7, 4'd3, 4'd2};

  function automatic kind_t kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0110111: return K_U;
      7'b1101111: return K_JAL;
      7'b1100011: return K_BEQ;
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic int last_step(input kind_t k);
    case (k)
      K_BEQ:   return 2;
      K_LW:    return 4;
      K_ILL:   return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bit mem_step();
    kind_t k = kind_of(op_code);
    return !m_boot && !m_fault && (m_step == 0 || (m_step == 3 && (k == K_LW || k == K_SW)));
  endfunction

  function automatic outs_t expect_outs();
    outs_t e;
    kind_t k;
    logic [3:0] cmd;
    e = '0;
    k = kind_of(op_code);
    cmd = alu_tab[funct_3];
    if (funct_3 == 3'd0 && op_code[5] && funct_7_bit_5) cmd = 4'd1;
    if (funct_3 == 3'd5 && funct_7_bit_5) cmd = 4'd8;
    if (!rst_n || m_boot) return e;
    if (m_fault) begin
      e.flt = 1'b1;
      e.cause = m_cause;
      return e;
    end
    case (k)
      K_SW:    e.imm = 3'd1;
      K_BEQ:   e.imm = 3'd2;
      K_JAL:   e.imm = 3'd3;
      K_U:     e.imm = 3'd4;
      default: e.imm = 3'd0;
    endcase
    if (m_step == 0) begin
      e.mem_req = 1'b1; e.b = 2'd2; e.res = 2'd2;
      e.ir_write = mem_ready; e.pc_write = mem_ready;
    end else if (m_step == 1) begin
      e.a = 2'd1; e.b = 2'd1;
    end else if (m_step == 2) begin
      case (k)
        K_R:   begin e.a = 2'd2; e.alu = cmd; end
        K_I:   begin e.a = 2'd2; e.b = 2'd1; e.alu = cmd; end
        K_U:   begin e.b = 2'd1; e.alu = 4'd9; end
        K_JAL: begin e.a = 2'd1; e.b = 2'd2; e.pc_write = 1'b1; end
        K_BEQ: begin e.a = 2'd2; e.alu = 4'd1; e.pc_write = zero; e.retire = 1'b1; end
        default: begin e.a = 2'd2; e.b = 2'd1; end
      endcase
    end else if (m_step == 3 && k == K_LW) begin
      e.adr_src = 1'b1; e.mem_req = 1'b1;
    end else if (m_step == 3 && k == K_SW) begin
      e.adr_src = 1'b1; e.mem_req = 1'b1; e.mem_write = 1'b1; e.retire = mem_ready;
    end else if (m_step == 4) begin
      e.res = 2'd1; e.reg_write = 1'b1; e.retire = 1'b1;
    end else begin
      e.reg_write = 1'b1; e.retire = 1'b1;
    end
    return e;
  endfunction

  function automatic outs_t dut_outs();
    outs_t d;
    d.mem_req = mem_req; d.mem_write = mem_write; d.adr_src = adr_src;
    d.ir_write = ir_write; d.pc_write = pc_write; d.reg_write = reg_write;
    d.res = result_src; d.a = alu_src_a; d.b = alu_src_b; d.imm = imm_src;
    d.alu = alu_control; d.retire = instr_retire; d.flt = fault; d.cause = fault_cause;
    return d;
  endfunction

  task automatic model_reset();
    m_boot = 1; m_fault = 0; m_cause = 2'd0; m_step = 0; m_stall = 0;
  endtask

  task automatic model_advance();
    kind_t k = kind_of(op_code);
    if (!rst_n) return;
    if (m_boot) begin
      m_boot = 0; m_step = 0; m_stall = 0;
    end else if (!m_fault) begin
      if (mem_step() && !mem_ready) begin
        m_stall++;
        if (m_stall >= TO) begin m_fault = 1; m_cause = 2'd2; m_stall = 0; end
      end else begin
        m_stall = 0;
        if (m_step == 1 && k == K_ILL) begin m_fault = 1; m_cause = 2'd1; end
        else if (m_step == last_step(k)) m_step = 0;
        else m_step++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name);
    outs_t e, a;
    e = expect_outs();
    a = dut_outs();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t op=%b step=%0d got=%h want=%h", name, $time, op_code, m_step, a, e);
    end
  endtask

  task automatic tick();
    check_vec("cycle");
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_vec("reset_async");
    chk("reset_mem_req", mem_req, 0);
    chk("reset_retire", instr_retire, 0);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      #1;
      tick();
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic zv, input int fwait, input int mwait, input int rst_at,
                           output int n, output logic [3:0] alu_seen, output logic pcw_seen);
    int fw, mw;
    outs_t e;
    op_code = op; funct_3 = f3; funct_7_bit_5 = f7; zero = zv;
    n = 0; fw = 0; mw = 0; alu_seen = 4'hF; pcw_seen = 1'b0;
    while (1) begin
      if (n >= 60) begin
        total++; bad++;
        $display("FAIL instr_budget op=%b cycles=%0d limit=60", op, n);
        break;
      end
      if (n == rst_at) begin
        do_reset();
        break;
      end
      if (!mem_step()) mem_ready = 1'($urandom_range(0, 1));
      else if (m_step == 0) begin mem_ready = (fw >= fwait); fw++; end
      else begin mem_ready = (mw >= mwait); mw++; end
      #1;
      e = expect_outs();
      if (!m_boot && !m_fault && m_step == 2) begin
        alu_seen = alu_control;
        pcw_seen = pc_write;
      end
      tick();
      n++;
      if (e.retire || m_fault) break;
    end
  endtask

  initial begin
    int n, sel, fw, mw, ra;
    logic [3:0] al;
    logic pw;
    logic [6:0] op;
    rst_n = 1'b0; op_code = '0; funct_3 = '0; funct_7_bit_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    model_reset();
    #12;
    check_vec("in_reset");
    chk("reset_vec", dut_outs(), 0);
    rst_n = 1'b1;
    #1;

    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, -1, n, al, pw);
    chk("add_retire_cycle", n, 5);
    chk("add_alu", al, 4'b0000);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, -1, n, al, pw);
    chk("sub_cycles", n, 4);
    chk("sub_alu", al, 4'b0001);
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, -1, n, al, pw);
    chk("addi_alu", al, 4'b0000);
    run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 0, 0, -1, n, al, pw);
    chk("srai_alu", al, 4'b1000);
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3, 3, -1, n, al, pw);
    chk("lw_cycles", n, 11);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, -1, n, al, pw);
    chk("beq_taken_pcw", pw, 1);
    chk("beq_cycles", n, 3);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, -1, n, al, pw);
    chk("beq_not_taken_pcw", pw, 0);

    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 100, 0, -1, n, al, pw);
    chk("timeout_cycles", n, 4);
    chk("timeout_fault", fault, 1);
    chk("timeout_cause", fault_cause, 2'b10);
    chk("timeout_req_low", mem_req, 0);
    idle(3);
    do_reset();
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 3, 0, -1, n, al, pw);
    chk("late_ready_cycles", n, 8);
    chk("late_ready_no_fault", fault, 0);

    run_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0, -1, n, al, pw);
    chk("illegal_cycles", n, 2);
    chk("illegal_cause", fault_cause, 2'b01);
    idle(20);
    chk("illegal_sticky", fault, 1);
    chk("illegal_sticky_cause", fault_cause, 2'b01);
    do_reset();
    chk("cleared_fault", fault, 0);
    chk("cleared_cause", fault_cause, 0);

    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 20);
      if (sel <= 2)       op = 7'b0110011;
      else if (sel <= 5)  op = 7'b0010011;
      else if (sel <= 7)  op = 7'b0110111;
      else if (sel <= 9)  op = 7'b1101111;
      else if (sel <= 12) op = 7'b1100011;
      else if (sel <= 15) op = 7'b0000011;
      else if (sel <= 18) op = 7'b0100011;
      else if (sel == 19) op = 7'b1110011;
      else                op = 7'b0001111;
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      ra = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), fw, mw, ra, n, al, pw);
      if (m_fault) begin
        idle(2);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main sequencing FSM for the multi-cycle RV32I-subset core.
- Decodes the latched instruction fields (opcode, funct3, funct7[5]) and drives PC/IR enables, memory handshake, register-file write, datapath mux selects, immediate format and the 4-bit ALU command every cycle.
- Handles the shared instruction/data memory port with a req/ready handshake and a watchdog timeout.
- Traps illegal opcodes and memory timeouts into a sticky fault state.

Parameters:
- TIMEOUT_CYCLES, 255, cycles mem_req may stay high without mem_ready before FAULT; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), watchdog counter width; derived, not overridden.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op_code  in  7  IR[6:0]
- funct_3  in  3  IR[14:12]
- funct_7_bit_5  in  1  IR[30]
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory accepts/completes the current access
- mem_req  out  1  memory access request
- mem_write  out  1  store (valid with mem_req)
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  latch IR/old-PC
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register-file write enable
- result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result direct
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SLT, 0110 XOR, 0111 SRL, 1000 SRA, 1001 PASS_B
- instr_retire  out  1  one-cycle pulse per completed instruction
- fault  out  1  sticky fault flag
- fault_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). State forced to BOOT, watchdog cleared, fault_cause = 00. Every output is 0 while in reset and in BOOT.
- BOOT: unconditionally goes to FETCH on the next edge.
- Outputs are Moore, except:
  - ir_write and pc_write in FETCH are gated by mem_ready.
  - pc_write in BEQ = zero.
  - Any output not listed for a state is 0, alu_control defaults to ADD.
- imm_src is decoded from op_code in every state:
  - I-ALU/lw → I; sw → S; beq → B; jal → J; lui → U; others → 000.
- FETCH:
  - Drives adr_src=0, mem_req=1, alu_src_a=00, alu_src_b=10, ADD, result_src=10.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE. Otherwise hold.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, ADD (branch/jump target into ALUOut).
  - Next state by opcode: 0000011/0100011 → MEM_ADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 0110111 → EXEC_U; 1101111 → JAL; 1100011 → BEQ; any other → FAULT with cause 01.
- MEM_ADR: alu_src_a=10, alu_src_b=01, ADD. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: adr_src=1, mem_req=1. On mem_ready → MEM_WB.
- MEM_WB: result_src=01, reg_write=1, instr_retire=1 → FETCH.
- MEM_WRITE: adr_src=1, mem_req=1, mem_write=1. On mem_ready: instr_retire=1 → FETCH.
- EXEC_R (alu_src_a=10, alu_src_b=00) and EXEC_I (alu_src_a=10, alu_src_b=01) both → ALU_WB. ALU command from funct_3:
  - 000: SUB if op_code[5] && funct_7_bit_5, else ADD.
  - 001 SLL; 010 SLT; 100 XOR; 110 OR; 111 AND.
  - 101: SRA if funct_7_bit_5, else SRL.
  - 011: ADD.
- EXEC_U: alu_src_b=01, PASS_B → ALU_WB.
- ALU_WB: result_src=00, reg_write=1, instr_retire=1 → FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1 → ALU_WB (writes link PC+4).
- BEQ: alu_src_a=10, alu_src_b=00, SUB, result_src=00, pc_write=zero, instr_retire=1 → FETCH.
- Memory handshake:
  - mem_req, adr_src and mem_write stay stable until mem_ready is sampled high at a rising edge.
  - mem_ready is ignored while mem_req=0.
  - A ready in the same cycle as the request completes the access in that single cycle.
- Watchdog:
  - Counts consecutive cycles with mem_req=1 and mem_ready=0; cleared on any mem_ready or when mem_req=0.
  - When the count reaches TIMEOUT_CYCLES (nonzero), next state is FAULT with cause 10.
  - If mem_ready arrives in the same cycle the limit is reached, ready wins: no fault.
- FAULT: all outputs 0 except fault=1 and fault_cause; sticky until rst_n is asserted.
- Reset mid-access: mem_req drops asynchronously; the bench must not see a stray retire.

Decomposition:
- Shared package core_pkg holds:
  - Opcode localparams.
  - alu_cmd_e (4-bit encodings above).
  - imm_src_e, result_src_e, src_a_e, src_b_e.
  - ctrl_state_e (BOOT, FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, EXEC_U, ALU_WB, JAL, BEQ, FAULT).
  - fault_cause_e.
- Sub-module alu_cmd_decoder: combinational mapping of funct_3/funct_7_bit_5/op_code[5] to alu_cmd_e.

Test Plan:
- Reset release, mem_ready tied 1, add x3,x1,x2 (op 0110011, f3 000, f7b5 0) → BOOT, FETCH, DECODE, EXEC_R (ADD), ALU_WB with reg_write=1; instr_retire at cycle 5; next FETCH.
- sub (f7b5=1), then addi with f7b5=1 (op 0010011) → SUB for the first, ADD for the second; srai (f3 101, f7b5=1) → 1000.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM_READ → mem_req/adr_src held stable; total 5+6 = 11 cycles; reg_write=1 with result_src=01.
- beq with zero=1, then beq with zero=0 → pc_write=1 in BEQ for the first only; both retire; imm_src=010 throughout.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH → FAULT after 4 stalled cycles, fault_cause=10, outputs 0. Repeat with ready on cycle 4 → no fault.
- Opcode 1110011 → FAULT from DECODE, cause 01, sticky across 20 cycles; async rst_n pulse mid-cycle clears it and returns all outputs to 0 immediately.
